signal_check_x16: RTL and testbench

Receive-side checker for the 16-channel test-pulse pattern and its spare trigger line on the padiwa board. The block sits where looped-back pulse lines come back into the FPGA. It opens a fixed window on each trigger rising edge and checks that every channel delivered exactly one pulse of legal width inside that window. It keeps per-event error flags, sticky stray-pulse flags and saturating event/error counters for slow-control readout.

---
 rtl/signal_check_pkg.sv | 30 +++
 rtl/signal_check_if.sv | 28 ++
 rtl/signal_check_ch.sv | 65 ++++++
 rtl/signal_check_x16.sv | 127 ++++++++++++
 tb/tb_signal_check_x16.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/signal_check_pkg.sv
// Shared types and helpers for the padiwa test-pulse receive checker.
// Holds the FSM states, the edge-count encoding and the width-counter sizing rule.
package signal_check_pkg;

    localparam int NUM_CH    = 16;
    localparam int WIN_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WIN  = 2'd1,
        RPT  = 2'd2
    } state_e;

    // Edge count saturates at two; anything other than exactly one is an error.
    typedef enum logic [1:0] {
        EDGE_NONE  = 2'd0,
        EDGE_ONE   = 2'd1,
        EDGE_MULTI = 2'd2
    } edge_cnt_e;

    // Width counter must hold MAX_WIDTH+1 as its saturation value.
    function automatic int width_cnt_bits(input int max_width);
        return $clog2(max_width + 2);
    endfunction

    function automatic edge_cnt_e edge_inc(input edge_cnt_e cnt);
        return (cnt == EDGE_NONE) ? EDGE_ONE : EDGE_MULTI;
    endfunction

endpackage

// File: rtl/signal_check_if.sv
// Pulse/trigger inputs and result/readout outputs of the signal checker.
// The stimulus side uses the master modport, the checker the slave modport.
interface signal_check_if #(
    parameter int CNT_W = 16
);
    import signal_check_pkg::*;

    logic [NUM_CH-1:0] pulse_in;
    logic              trig_in;
    logic              clear_counts;
    logic              event_done;
    logic              event_ok;
    logic [NUM_CH-1:0] ch_err;
    logic [NUM_CH-1:0] stray;
    logic [CNT_W-1:0]  event_count;
    logic [CNT_W-1:0]  err_count;

    modport master (
        output pulse_in, trig_in, clear_counts,
        input  event_done, event_ok, ch_err, stray, event_count, err_count
    );

    modport slave (
        input  pulse_in, trig_in, clear_counts,
        output event_done, event_ok, ch_err, stray, event_count, err_count
    );

endinterface

// File: rtl/signal_check_ch.sv
// One channel's pulse checker: edge count, pulse width and stray-edge detection.
// The error output is a plain function of the state and is sampled by the top in RPT.
module signal_check_ch
    import signal_check_pkg::*;
#(
    parameter int MIN_WIDTH = 3,
    parameter int MAX_WIDTH = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic rise,
    input  logic fall,
    input  logic level,
    input  logic start,
    input  logic in_win,
    input  logic idle,
    input  logic clear,
    output logic err,
    output logic stray
);

    localparam int WID_W = width_cnt_bits(MAX_WIDTH);
    localparam logic [WID_W-1:0] W_SAT = WID_W'(MAX_WIDTH + 1);
    localparam logic [WID_W-1:0] W_MIN = WID_W'(MIN_WIDTH);
    localparam logic [WID_W-1:0] W_MAX = WID_W'(MAX_WIDTH);

    logic [WID_W-1:0] width_cnt;
    logic [WID_W-1:0] width_lat;
    edge_cnt_e        edge_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            width_cnt <= '0;
            width_lat <= '0;
            edge_cnt  <= EDGE_NONE;
            stray     <= 1'b0;
        end else begin
            // On the fall cycle width_cnt still holds the number of high cycles.
            if (level) begin
                width_cnt <= (width_cnt == W_SAT) ? W_SAT : width_cnt + 1'b1;
            end else begin
                width_cnt <= '0;
            end

            if (start) begin
                edge_cnt  <= rise ? EDGE_ONE : EDGE_NONE;
                width_lat <= '0;
            end else if (in_win) begin
                if (rise) edge_cnt <= edge_inc(edge_cnt);
                if (fall) width_lat <= width_cnt;
            end

            if (clear) begin
                stray <= 1'b0;
            end else if (idle && rise) begin
                stray <= 1'b1;
            end
        end
    end

    // In RPT a non-zero width_cnt means the line was still high in the last window cycle.
    assign err = (edge_cnt != EDGE_ONE) || (width_lat < W_MIN) ||
                 (width_lat > W_MAX) || (width_cnt != '0);

endmodule

// File: rtl/signal_check_x16.sv
// Receive-side checker for the 16-channel padiwa test-pulse pattern and its trigger.
// Synchronises all lines, runs the window FSM and keeps saturating readout counters.
module signal_check_x16
    import signal_check_pkg::*;
#(
    parameter int WINDOW    = 16,
    parameter int MIN_WIDTH = 3,
    parameter int MAX_WIDTH = 6,
    parameter int CNT_W     = 16
) (
    input logic           clk,
    input logic           reset,
    signal_check_if.slave bus
);

    localparam int TRIG = NUM_CH;
    // win_cnt starts at 0 in the first WIN cycle, which is window cycle 1.
    localparam logic [WIN_CNT_W-1:0] WIN_LAST = WIN_CNT_W'(WINDOW - 2);

    logic [NUM_CH:0]   sync1, sync2, sync3, rise_q;
    logic [NUM_CH-1:0] fall_q;
    logic [NUM_CH-1:0] err_vec, stray_vec;

    state_e                 state;
    logic [WIN_CNT_W-1:0]   win_cnt;
    logic                   event_done, event_ok;
    logic [NUM_CH-1:0]      ch_err;
    logic [CNT_W-1:0]       event_count, err_count;
    logic                   trig_rise, start, in_win, idle_open;

    // NOTE: every flop stage uses <= so each stage samples the previous one's old value;
    // blocking assignments here would collapse the synchroniser into a single flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            sync3  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync1  <= {bus.trig_in, bus.pulse_in};
            sync2  <= sync1;
            sync3  <= sync2;
            rise_q <= sync2 & ~sync3;
            fall_q <= ~sync2[NUM_CH-1:0] & sync3[NUM_CH-1:0];
        end
    end

    assign trig_rise = rise_q[TRIG];
    assign start     = (state == IDLE) && trig_rise;
    assign in_win    = (state == WIN);
    assign idle_open = (state == IDLE) && !trig_rise;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        signal_check_ch #(
            .MIN_WIDTH (MIN_WIDTH),
            .MAX_WIDTH (MAX_WIDTH)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .rise   (rise_q[i]),
            .fall   (fall_q[i]),
            .level  (sync3[i]),
            .start  (start),
            .in_win (in_win),
            .idle   (idle_open),
            .clear  (bus.clear_counts),
            .err    (err_vec[i]),
            .stray  (stray_vec[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            win_cnt    <= '0;
            event_done <= 1'b0;
            event_ok   <= 1'b0;
            ch_err     <= '0;
        end else begin
            event_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_rise) begin
                        state   <= WIN;
                        win_cnt <= '0;
                    end
                end
                WIN: begin
                    win_cnt <= win_cnt + 1'b1;
                    if (win_cnt == WIN_LAST) begin
                        state      <= RPT;
                        event_done <= 1'b1;
                    end
                end
                RPT: begin
                    state    <= IDLE;
                    ch_err   <= err_vec;
                    event_ok <= ~|err_vec;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clear takes priority over an RPT update landing on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            event_count <= '0;
            err_count   <= '0;
        end else if (bus.clear_counts) begin
            event_count <= '0;
            err_count   <= '0;
        end else if (state == RPT) begin
            if (event_count != '1) event_count <= event_count + 1'b1;
            if ((|err_vec) && (err_count != '1)) err_count <= err_count + 1'b1;
        end
    end

    assign bus.event_done  = event_done;
    assign bus.event_ok    = event_ok;
    assign bus.ch_err      = ch_err;
    assign bus.stray       = stray_vec;
    assign bus.event_count = event_count;
    assign bus.err_count   = err_count;

endmodule

// File: tb/tb_signal_check_x16.sv
// Scoreboard bench for signal_check_x16: per-cycle waveforms drive 16 channels plus trigger,
// expected event results are queued at stimulus time and compared when event_done fires.
module tb_signal_check_x16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pulse_drv = '0;
    logic        trig_drv = 1'b0;
    logic        clear_drv = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] ch_err;
        logic        ok;
    } exp_t;
    exp_t exp_q[$];

    // Bit c of wave[k] is the pin level in stimulus cycle c; index 16 is the trigger.
    logic [31:0] wave [17];

    always #5 clk = ~clk;

    signal_check_if #(.CNT_W(16)) bus1 ();
    signal_check_if #(.CNT_W(2))  bus2 ();

    assign bus1.pulse_in     = pulse_drv;
    assign bus1.trig_in      = trig_drv;
    assign bus1.clear_counts = clear_drv;
    assign bus2.pulse_in     = pulse_drv;
    assign bus2.trig_in      = trig_drv;
    assign bus2.clear_counts = clear_drv;

    signal_check_x16 #(.WINDOW(16), .MIN_WIDTH(3), .MAX_WIDTH(6), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    signal_check_x16 #(.WINDOW(16), .MIN_WIDTH(3), .MAX_WIDTH(6), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_waves(input logic [15:0] mask, input logic [31:0] trig_wave);
        for (int k = 0; k < 16; k++) wave[k] = mask[k] ? 32'h0000_000F : 32'h0;
        wave[16] = trig_wave;
    endtask

    task automatic play(input int reset_at, input bit clr_on_done);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            for (int k = 0; k < 16; k++) pulse_drv[k] = wave[k][c];
            trig_drv  = wave[16][c];
            clear_drv = clr_on_done && bus1.event_done;
            if (c == reset_at) reset = 1'b1;
        end
        clear_drv = 1'b0;
    endtask

    task automatic run_event(input logic [15:0] exp_err, input int gap);
        exp_t e;
        e.ch_err = exp_err;
        e.ok     = (exp_err == 16'h0);
        exp_q.push_back(e);
        play(-1, 1'b0);
        idle(gap);
        check("pending_events", exp_q.size(), 0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_drv = 1'b1;
        @(negedge clk);
        clear_drv = 1'b0;
        idle(2);
    endtask

    // Scoreboard monitor: results are compared one cycle after the strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus1.event_done === 1'b1) begin
                @(negedge clk);
                check("done_one_cycle", bus1.event_done, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_event_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ch_err", bus1.ch_err, e.ch_err);
                    check("event_ok", bus1.event_ok, e.ok);
                end
            end
        end
    end

    initial begin
        idle(3);
        reset = 1'b0;
        idle(3);
        check("rst_event_done", bus1.event_done, 0);
        check("rst_event_ok", bus1.event_ok, 0);
        check("rst_ch_err", bus1.ch_err, 0);
        check("rst_stray", bus1.stray, 0);
        check("rst_event_count", bus1.event_count, 0);
        check("rst_err_count", bus1.err_count, 0);

        // Three good events at the generator's 12000-cycle period.
        set_waves(16'hFFFF, 32'hF);
        for (int i = 0; i < 3; i++) run_event(16'h0000, 12000 - 32);
        check("good_event_count", bus1.event_count, 3);
        check("good_err_count", bus1.err_count, 0);

        // Channel 5 silent.
        set_waves(16'hFFDF, 32'hF);
        run_event(16'h0020, 40);
        check("ch5_err_count", bus1.err_count, 1);
        check("ch5_event_count", bus1.event_count, 4);

        // Too wide, too narrow, double pulse.
        set_waves(16'hFFFF, 32'hF);
        wave[0] = 32'h0000_00FF;
        run_event(16'h0001, 40);
        set_waves(16'hFFFF, 32'hF);
        wave[1] = 32'h0000_0003;
        run_event(16'h0002, 40);
        set_waves(16'hFFFF, 32'hF);
        wave[15] = 32'h0000_03CF;
        run_event(16'h8000, 40);
        check("width_err_count", bus1.err_count, 4);

        // Stray pulse on channel 3 well outside any window.
        idle(100);
        set_waves(16'h0008, 32'h0);
        play(-1, 1'b0);
        idle(4);
        check("stray_ch3", bus1.stray, 16'h0008);
        set_waves(16'hFFFF, 32'hF);
        run_event(16'h0000, 40);
        check("stray_sticky", bus1.stray, 16'h0008);
        check("stray_event_count", bus1.event_count, 8);
        pulse_clear();
        check("clear_stray", bus1.stray, 0);
        check("clear_event_count", bus1.event_count, 0);
        check("clear_err_count", bus1.err_count, 0);

        // Retrigger 5 cycles later inside the window is ignored.
        set_waves(16'hFFFF, 32'h0000_01EF);
        run_event(16'h0000, 40);
        check("retrig_event_count", bus1.event_count, 1);

        // Reset at window cycle 7 abandons the event.
        set_waves(16'hFFFF, 32'hF);
        play(10, 1'b0);
        idle(4);
        reset = 1'b0;
        idle(20);
        check("wrst_event_ok", bus1.event_ok, 0);
        check("wrst_ch_err", bus1.ch_err, 0);
        check("wrst_stray", bus1.stray, 0);
        check("wrst_event_count", bus1.event_count, 0);
        check("wrst_err_count", bus1.err_count, 0);
        run_event(16'h0000, 40);
        check("post_rst_event_count", bus1.event_count, 1);
        check("post_rst_err_count", bus1.err_count, 0);

        // Five failing events: 2-bit counters saturate at 3.
        pulse_clear();
        set_waves(16'hFFDF, 32'hF);
        for (int i = 0; i < 5; i++) run_event(16'h0020, 40);
        check("sat16_event_count", bus1.event_count, 5);
        check("sat16_err_count", bus1.err_count, 5);
        check("sat2_event_count", bus2.event_count, 3);
        check("sat2_err_count", bus2.err_count, 3);

        // Clear landing on the RPT edge wins over the counter update.
        set_waves(16'hFFDF, 32'hF);
        begin
            exp_t e;
            e.ch_err = 16'h0020;
            e.ok     = 1'b0;
            exp_q.push_back(e);
        end
        play(-1, 1'b1);
        idle(10);
        check("pending_events", exp_q.size(), 0);
        check("clr_rpt_event_count", bus1.event_count, 0);
        check("clr_rpt_err_count", bus1.err_count, 0);
        check("clr_rpt_sat2_event_count", bus2.event_count, 0);
        check("clr_rpt_event_ok", bus1.event_ok, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
